slt_seq: RTL and testbench

Digit-serial, parametrised compare unit: the multi-cycle successor to the combinational 32-bit set-less-than. It compares two WIDTH-bit operands DIGIT bits per cycle, MSB digit first. Four compare modes are supported. Results use the MiniMIPS set-style format: WIDTH-bit word, value 0 or 1 in bit 0. It sits beside the ALU as a low-area compare path with a valid/ready handshake on both input and output.

---
 rtl/slt_pkg.sv | 51 +++++
 rtl/slt_digit_cmp.sv | 23 ++
 rtl/slt_seq.sv | 135 +++++++++++++
 tb/tb_slt_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/slt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : slt_pkg
//  Brief    : Shared op/state encodings and sizing helpers for the digit-serial
//             compare unit.
//  Revision : 1.0 - initial release
// ============================================================================
package slt_pkg;

  // Compare modes
  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_SEQ  = 2'b10;
  localparam logic [1:0] OP_SLE  = 2'b11;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of digit steps needed to cover the operand
  function automatic int calc_nsteps(input int width, input int digit);
    return width / digit;
  endfunction

  // Step counter width; at least one bit even for a single-step compare
  function automatic int calc_cnt_w(input int width, input int digit);
    int n;
    n = width / digit;
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Signed modes bias the sign bit so an unsigned compare orders them correctly
  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_SLT) || (op == OP_SLE);
  endfunction

  // Map the final less/greater flags to the set-style outcome bit
  function automatic logic set_result(input logic [1:0] op, input logic lt,
                                      input logic gt);
    logic res;
    case (op)
      OP_SLT, OP_SLTU: res = lt;
      OP_SEQ:          res = !lt && !gt;
      default:         res = lt || (!lt && !gt);
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slt_digit_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : slt_digit_cmp
//  Brief    : Combinational unsigned compare of one DIGIT-bit digit pair.
//  Revision : 1.0 - initial release
// ============================================================================
module slt_digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             gt
);

  // Plain magnitude compare; sign handling is done by the parent
  always_comb begin
    lt = (a < b);
    gt = (a > b);
  end

endmodule
`default_nettype wire

// File: rtl/slt_seq.sv
`default_nettype none
// ============================================================================
//  Module   : slt_seq
//  Brief    : Digit-serial SLT/SLTU/SEQ/SLE compare unit, MSB digit first,
//             with valid/ready handshakes on request and result.
//  Revision : 1.0 - initial release
// ============================================================================
module slt_seq
  import slt_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             busy
);

  localparam int NSTEPS = calc_nsteps(WIDTH, DIGIT);
  localparam int CNT_W  = calc_cnt_w(WIDTH, DIGIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEPS - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lt_q, lt_d, gt_q, gt_d;
  logic             res_q, res_d;
  logic [WIDTH-1:0] a_shl, b_shl;
  logic             digit_lt, digit_gt;

  // Operands shift left one digit per step so the current digit is always on top
  generate
    if (NSTEPS > 1) begin : g_shift
      assign a_shl = {a_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
      assign b_shl = {b_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
    end else begin : g_no_shift
      assign a_shl = '0;
      assign b_shl = '0;
    end
  endgenerate

  slt_digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .a  (a_q[WIDTH-1 -: DIGIT]),
    .b  (b_q[WIDTH-1 -: DIGIT]),
    .lt (digit_lt),
    .gt (digit_gt)
  );

  // Next-state logic: capture, digit walk with sticky first-difference flags, hand-off
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Sign bit is flipped once at capture; it lands in the first digit compared
          a_d     = is_signed_op(op) ? (A ^ MSB_MASK) : A;
          b_d     = is_signed_op(op) ? (B ^ MSB_MASK) : B;
          op_d    = op;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        a_d   = a_shl;
        b_d   = b_shl;
        cnt_d = cnt_q + 1'b1;
        // Only the most significant differing digit decides the order
        if (!lt_q && !gt_q) begin
          lt_d = digit_lt;
          gt_d = digit_gt;
        end
        if ((cnt_q == LAST_CNT) || ((EARLY_EXIT != 0) && (lt_d || gt_d))) begin
          state_d = ST_DONE;
          res_d   = set_result(op_q, lt_d, gt_d);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign R         = {{(WIDTH-1){1'b0}}, res_q};

endmodule
`default_nettype wire

// File: tb/tb_slt_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slt_seq
//  Brief    : Directed bench for slt_seq across default, early-exit and two
//             alternate width/digit configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slt_seq;
  import slt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: defaults (32/4, fixed latency)
  logic iv0 = 0, ir0, ov0, or0 = 0, busy0;
  logic [1:0] op0 = 0;
  logic [31:0] a0 = 0, b0 = 0, r0;
  // DUT 1: 32/4 with early exit
  logic iv1 = 0, ir1, ov1, or1 = 0, busy1;
  logic [1:0] op1 = 0;
  logic [31:0] a1 = 0, b1 = 0, r1;
  // DUT 2: 8/1
  logic iv2 = 0, ir2, ov2, or2 = 0, busy2;
  logic [1:0] op2 = 0;
  logic [7:0] a2 = 0, b2 = 0, r2;
  // DUT 3: 16/16
  logic iv3 = 0, ir3, ov3, or3 = 0, busy3;
  logic [1:0] op3 = 0;
  logic [15:0] a3 = 0, b3 = 0, r3;

  slt_seq u_dut0 (.clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .op(op0),
                  .A(a0), .B(b0), .out_valid(ov0), .out_ready(or0), .R(r0), .busy(busy0));
  slt_seq #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(1)) u_dut1 (
                  .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op1),
                  .A(a1), .B(b1), .out_valid(ov1), .out_ready(or1), .R(r1), .busy(busy1));
  slt_seq #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(0)) u_dut2 (
                  .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op(op2),
                  .A(a2), .B(b2), .out_valid(ov2), .out_ready(or2), .R(r2), .busy(busy2));
  slt_seq #(.WIDTH(16), .DIGIT(16), .EARLY_EXIT(0)) u_dut3 (
                  .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .op(op3),
                  .A(a3), .B(b3), .out_valid(ov3), .out_ready(or3), .R(r3), .busy(busy3));

  typedef struct {
    int          dut;
    logic [31:0] r;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b);
    case (d)
      0: begin iv0 = v; op0 = o; a0 = a; b0 = b; end
      1: begin iv1 = v; op1 = o; a1 = a; b1 = b; end
      2: begin iv2 = v; op2 = o; a2 = a[7:0]; b2 = b[7:0]; end
      default: begin iv3 = v; op3 = o; a3 = a[15:0]; b3 = b[15:0]; end
    endcase
  endtask

  task automatic set_ordy(input int d, input logic v);
    case (d)
      0: or0 = v;
      1: or1 = v;
      2: or2 = v;
      default: or3 = v;
    endcase
  endtask

  function automatic logic get_ov(input int d);
    case (d) 0: return ov0; 1: return ov1; 2: return ov2; default: return ov3; endcase
  endfunction
  function automatic logic get_ir(input int d);
    case (d) 0: return ir0; 1: return ir1; 2: return ir2; default: return ir3; endcase
  endfunction
  function automatic logic get_busy(input int d);
    case (d) 0: return busy0; 1: return busy1; 2: return busy2; default: return busy3; endcase
  endfunction
  function automatic logic [31:0] get_r(input int d);
    case (d)
      0: return r0;
      1: return r1;
      2: return {24'd0, r2};
      default: return {16'd0, r3};
    endcase
  endfunction

  // Wait for the result, compare against the scoreboard, optionally stall, then drain
  task automatic collect(input int d, input bit hold);
    int lat = 0;
    exp_t e;
    logic [31:0] held;
    while (!get_ov(d) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_seen", {31'd0, get_ov(d)}, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("dut_index", d, e.dut);
    check("latency", 32'(lat), 32'(e.lat));
    check("result", get_r(d), e.r);
    if (hold) begin
      held = get_r(d);
      for (int i = 0; i < 5; i++) begin
        if (i == 2) set_in(d, 1'b1, OP_SLTU, 32'h1, 32'h2);
        if (i == 3) set_in(d, 1'b0, OP_SLTU, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("stall_r_stable", get_r(d), held);
        check("stall_out_valid", {31'd0, get_ov(d)}, 32'd1);
        check("stall_in_ready", {31'd0, get_ir(d)}, 32'd0);
      end
    end
    set_ordy(d, 1'b1);
    @(posedge clk); #1;
    set_ordy(d, 1'b0);
    check("drain_out_valid", {31'd0, get_ov(d)}, 32'd0);
    check("drain_in_ready", {31'd0, get_ir(d)}, 32'd1);
    if (hold) begin
      @(posedge clk); #1;
      check("ignored_pulse_idle", {31'd0, get_busy(d)}, 32'd0);
    end
  endtask

  // Issue one request; operands are scrambled right after accept
  task automatic request(input int d, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input int el,
                         input bit hold);
    sb.push_back('{d, er, el});
    @(negedge clk);
    check("in_ready_before_req", {31'd0, get_ir(d)}, 32'd1);
    set_in(d, 1'b1, o, a, b);
    @(posedge clk); #1;
    set_in(d, 1'b0, ~o, ~a, ~b);
    check("busy_after_accept", {31'd0, get_busy(d)}, 32'd1);
    check("in_ready_after_accept", {31'd0, get_ir(d)}, 32'd0);
    collect(d, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check("reset_in_ready", {31'd0, get_ir(d)}, 32'd1);
      check("reset_out_valid", {31'd0, get_ov(d)}, 32'd0);
      check("reset_busy", {31'd0, get_busy(d)}, 32'd0);
      check("reset_r", get_r(d), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed latency, signed vs unsigned on the same operand pairs
    request(0, OP_SLT,  32'hFFFF_FFFF, 32'h40A0_0400, 32'd1, 8, 1'b0);
    request(0, OP_SLTU, 32'hFFFF_FFFF, 32'h40A0_0400, 32'd0, 8, 1'b0);
    request(0, OP_SLT,  32'h2222_0225, 32'hC242_0423, 32'd0, 8, 1'b0);
    request(0, OP_SLTU, 32'h2222_0225, 32'hC242_0423, 32'd1, 8, 1'b0);

    // Early exit on first differing digit; equal operands run the full length
    request(1, OP_SLTU, 32'h2222_0225, 32'hC242_0423, 32'd1, 1, 1'b0);
    request(1, OP_SEQ,  32'h1234_5678, 32'h1234_5678, 32'd1, 8, 1'b0);
    request(1, OP_SLE,  32'h1234_5678, 32'h1234_5678, 32'd1, 8, 1'b0);
    request(1, OP_SLT,  32'h1234_5678, 32'h1234_5678, 32'd0, 8, 1'b0);

    // Backpressure with an ignored in_valid pulse while holding the result
    request(0, OP_SLT,  32'hFFFF_FFFF, 32'h40A0_0400, 32'd1, 8, 1'b1);

    // Asynchronous reset in the third CMP cycle aborts the operation
    @(negedge clk);
    set_in(0, 1'b1, OP_SLTU, 32'h1, 32'h2);
    @(posedge clk); #1;
    set_in(0, 1'b0, OP_SLTU, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, ir0}, 32'd1);
    check("abort_out_valid", {31'd0, ov0}, 32'd0);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_r", r0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    request(0, OP_SLTU, 32'd5, 32'd7, 32'd1, 8, 1'b0);

    // Alternate geometries
    request(2, OP_SLT,  32'h80, 32'h7F, 32'd1, 8, 1'b0);
    request(3, OP_SLTU, 32'hFFFF, 32'h0000, 32'd0, 1, 1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
